seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Reader for the team's multiplexed seven-segment display bus.
- Samples segment lines plus one-hot digit strobes, waits for each digit's pattern to be stable, and decodes it back to BCD.
- Assembles one full scan of all digits and publishes it as a single frame.
- Sits on the monitor/self-check side of the display driver, or ahead of any logic that must read a scanned display.

Parameters:
N_DIGITS, 4, number of multiplexed digits (strobe width).
STABLE_CYCLES, 4, consecutive identical registered samples (>=2) required before a digit is captured.
TIMEOUT_CYCLES, 1024, cycles without any capture before sync is declared lost.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
seg_in  in  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-high.
dig_sel  in  N_DIGITS  digit strobe, active-high, bit i = digit i.
frame_valid  out  1  one-cycle pulse: new frame on bcd_out/blank_mask/err_mask.
bcd_out  out  4*N_DIGITS  digit i at [4i+3:4i]; held between frames.
blank_mask  out  N_DIGITS  digit i was blank (seg 7'h00).
err_mask  out  N_DIGITS  digit i held an undecodable pattern.
sync_lost  out  1  high while no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset clears every output to 0, clears slots and the captured mask, sets cnt = 0 and the timeout counter to 0, and enters state COLLECT. A reset asserted mid-frame discards all partial captures.
- Input stage: {dig_sel, seg_in} is registered every cycle into samp.
  - If the incoming value differs from samp, cnt <= 1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Capture: happens on the edge where incoming == samp, cnt == STABLE_CYCLES-1, and samp.dig_sel is exactly one-hot with index k.
  - Writes slot[k] = decode(samp.seg).
  - At most one capture per stable dwell.
  - If samp.dig_sel is zero or multi-hot, no capture occurs and the dwell is ignored.
- Decode table (seg -> bcd):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 00 gives bcd F with the blank flag set.
  - Any other pattern gives bcd F with the err flag set.
- Frame state machine:
  - COLLECT: a capture of digit k sets captured[k].
    - If captured[k] was already set, a new scan has started. captured <= only bit k, slot[k] is overwritten, and the other slots are stale and will be rewritten.
    - When a capture makes captured all-ones, go to PUBLISH.
  - PUBLISH (1 cycle):
    - bcd_out, blank_mask and err_mask are loaded from the slots.
    - frame_valid = 1; captured is cleared; next state is COLLECT.
    - A capture on this edge is recorded into the fresh mask.
- Latency: digit k's stable input is first sampled at edge e1 and captured at edge e(STABLE_CYCLES). If that capture completes the frame, frame_valid is high for the cycle after edge e(STABLE_CYCLES+1).
- Timeout: the counter clears on any capture and otherwise increments. On reaching TIMEOUT_CYCLES:
  - sync_lost goes to 1 and captured is cleared.
  - The counter holds.
  - sync_lost returns to 0 on the edge of the next capture.
  - bcd_out keeps its last frame.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- Defined:
  - seg_in widens to 8 bits, with the decimal point at bit 7.
  - A dp_mask output (N_DIGITS) is added and published with each frame.
  - The dp bit takes part in stability comparison but not in decode.
- Undefined: seg_in is 7 bits and dp_mask does not exist.

Decomposition:
- Package seg_pkg:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - BCD_INVALID = 4'hF;
  - state encoding COLLECT/PUBLISH.
- Sub-module seg_pattern_decode: combinational 7-bit -> {bcd[3:0], blank, err}, shared with future readers.

Test Plan:
- Scan digits 0..3 with patterns 5B,30,6D,7E, each held 6 cycles -> one frame_valid pulse; bcd_out = 16'h0215 (digit 3 = 0, digit 2 = 2, digit 1 = 1, digit 0 = 5); blank_mask = 0; err_mask = 0.
- Hold digit 2 for only 3 cycles (STABLE_CYCLES = 4) -> no capture for digit 2 and no frame; a subsequent 4-cycle dwell -> frame published with cycle-exact latency.
- Patterns 00 and 7C on digits 1 and 3 -> bcd nibbles F; blank_mask = 4'b0010; err_mask = 4'b1000.
- dig_sel = 4'b0110 held 10 cycles, then 4'b0000 -> no captures, captured mask unchanged.
- Capture digits 0,1, then digit 0 again, then digits 1..3 -> exactly one frame, containing the latest values for all digits.
- Drive no strobes for 1024 cycles -> sync_lost = 1 and bcd_out unchanged; the next capture clears it. Assert rst mid-frame -> all outputs 0 and no frame_valid afterward until a full scan completes.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: shared constants for the seven-segment scan reader.
//   SEG_0..SEG_9, SEG_BLANK : segment codes {a,b,c,d,e,f,g}, a = bit 6
//   BCD_INVALID             : nibble reported for blank / undecodable digits
//   SEG_W                   : width of seg_in (8 with SEG_SCAN_DP_EN, else 7)
//   frame_state_e           : frame assembler states COLLECT / PUBLISH
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_INVALID = 4'hF;

`ifdef SEG_SCAN_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } frame_state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display bus in, decoded frame out.
//   seg_in      : segment lines (bit 7 = decimal point when SEG_SCAN_DP_EN)
//   dig_sel     : one-hot digit strobes
//   frame_valid : one-cycle pulse, new frame on bcd_out/blank_mask/err_mask
//   bcd_out     : digit i at [4i+3:4i]
//   blank_mask  : digit i was blank
//   err_mask    : digit i was undecodable
//   sync_lost   : no capture for TIMEOUT_CYCLES
//   dp_mask     : decimal points per digit (SEG_SCAN_DP_EN only)
// master = display side / observer, slave = the reader.
interface seg_scan_decoder_if
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4
);
  logic [SEG_W-1:0]      seg_in;
  logic [N_DIGITS-1:0]   dig_sel;
  logic                  frame_valid;
  logic [4*N_DIGITS-1:0] bcd_out;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   err_mask;
  logic                  sync_lost;
`ifdef SEG_SCAN_DP_EN
  logic [N_DIGITS-1:0]   dp_mask;

  modport master (output seg_in, dig_sel,
                  input  frame_valid, bcd_out, blank_mask, err_mask, sync_lost, dp_mask);
  modport slave  (input  seg_in, dig_sel,
                  output frame_valid, bcd_out, blank_mask, err_mask, sync_lost, dp_mask);
`else
  modport master (output seg_in, dig_sel,
                  input  frame_valid, bcd_out, blank_mask, err_mask, sync_lost);
  modport slave  (input  seg_in, dig_sel,
                  output frame_valid, bcd_out, blank_mask, err_mask, sync_lost);
`endif
endinterface

// File: rtl/seg_scan_decoder_decode.sv
// seg_pattern_decode: combinational seven-segment -> BCD decoder.
//   seg_i   : {a,b,c,d,e,f,g}, a = bit 6
//   bcd_o   : decoded digit, BCD_INVALID for blank or unknown patterns
//   blank_o : pattern was all-off
//   err_o   : pattern is not a recognised digit
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       err_o
);
  always_comb begin
    bcd_o   = BCD_INVALID;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads a multiplexed seven-segment display bus, waits for
// each digit to be stable, decodes it and publishes one full scan as a frame.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seg_scan_decoder_if.slave (segment/strobe inputs, frame outputs)
// Optional: SEG_SCAN_DP_EN adds the decimal point (seg_in bit 7) and dp_mask.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic               clk,
  input  logic               rst,
  seg_scan_decoder_if.slave  bus
);
  localparam int SW = N_DIGITS + SEG_W;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [SW-1:0]         samp_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  frame_state_e          state_q, state_d;
  logic [N_DIGITS-1:0]   captured_q, captured_d;
  logic [4*N_DIGITS-1:0] bcd_slot_q;
  logic [N_DIGITS-1:0]   blank_slot_q, err_slot_q;
  logic                  frame_valid_q, sync_lost_q, sync_lost_d;
  logic [4*N_DIGITS-1:0] bcd_out_q;
  logic [N_DIGITS-1:0]   blank_mask_q, err_mask_q;

  logic [SW-1:0]       incoming;
  logic [N_DIGITS-1:0] samp_dig, fresh;
  logic [SEG_W-1:0]    samp_seg;
  logic                same, onehot, cap, publish;
  logic [IW-1:0]       cap_idx;
  logic [3:0]          dec_bcd;
  logic                dec_blank, dec_err;

  assign incoming = {bus.dig_sel, bus.seg_in};
  assign samp_dig = samp_q[SW-1:SEG_W];
  assign samp_seg = samp_q[SEG_W-1:0];
  assign same     = (incoming == samp_q);
  assign onehot   = (samp_dig != '0) && ((samp_dig & (samp_dig - 1'b1)) == '0);
  // cnt saturates at STABLE_CYCLES, so the CNT_CAP match fires once per dwell
  assign cap      = same && (cnt_q == CNT_CAP) && onehot;

  seg_pattern_decode u_dec (
    .seg_i   (samp_seg[6:0]),
    .bcd_o   (dec_bcd),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  always_comb begin
    cap_idx = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      if (samp_dig[i]) cap_idx = IW'(i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!same)               cnt_d = CW'(1);
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    to_cnt_d = to_cnt_q;
    if (cap)                 to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
    sync_lost_d = (to_cnt_d == TO_MAX);
  end

  // Frame assembler: a repeated digit restarts the scan; a capture on the
  // PUBLISH edge seeds the next frame's mask.
  always_comb begin
    publish = 1'b0;
    fresh   = captured_q;
    case (state_q)
      COLLECT: if (cap) fresh = ((captured_q & samp_dig) != '0) ? samp_dig
                                                                 : (captured_q | samp_dig);
      PUBLISH: begin
        publish = 1'b1;
        fresh   = cap ? samp_dig : '0;
      end
      default: fresh = '0;
    endcase
    captured_d = fresh;
    state_d    = (cap && (&fresh)) ? PUBLISH : COLLECT;
    if (sync_lost_d) captured_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      captured_q <= '0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q        <= '0;
      cnt_q         <= '0;
      to_cnt_q      <= '0;
      bcd_slot_q    <= '0;
      blank_slot_q  <= '0;
      err_slot_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_lost_q   <= 1'b0;
      bcd_out_q     <= '0;
      blank_mask_q  <= '0;
      err_mask_q    <= '0;
    end else begin
      samp_q        <= incoming;
      cnt_q         <= cnt_d;
      to_cnt_q      <= to_cnt_d;
      sync_lost_q   <= sync_lost_d;
      frame_valid_q <= publish;
      if (cap) begin
        bcd_slot_q[4*cap_idx +: 4] <= dec_bcd;
        blank_slot_q[cap_idx]      <= dec_blank;
        err_slot_q[cap_idx]        <= dec_err;
      end
      if (publish) begin
        bcd_out_q    <= bcd_slot_q;
        blank_mask_q <= blank_slot_q;
        err_mask_q   <= err_slot_q;
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [N_DIGITS-1:0] dp_slot_q, dp_mask_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_slot_q <= '0;
      dp_mask_q <= '0;
    end else begin
      if (cap)     dp_slot_q[cap_idx] <= samp_seg[7];
      if (publish) dp_mask_q <= dp_slot_q;
    end
  end
  assign bus.dp_mask = dp_mask_q;
`endif

  assign bus.frame_valid = frame_valid_q;
  assign bus.bcd_out     = bcd_out_q;
  assign bus.blank_mask  = blank_mask_q;
  assign bus.err_mask    = err_mask_q;
  assign bus.sync_lost   = sync_lost_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (N_DIGITS=4, STABLE_CYCLES=4,
// TIMEOUT_CYCLES=1024) with hand-computed expected frames.
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   fv_count = 0;
  int   fv_base;
  int   lat;

  seg_scan_decoder_if #(.N_DIGITS(4)) bus ();

  seg_scan_decoder #(
    .N_DIGITS       (4),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // frame_valid is registered; one count per high cycle
  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] dig, input logic [6:0] seg, input int n);
    bus.dig_sel = dig;
    bus.seg_in  = '0;
    bus.seg_in[6:0] = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] bcd,
                             input logic [3:0] blank, input logic [3:0] err);
    check({tag, "_bcd"},   32'(bus.bcd_out),    32'(bcd));
    check({tag, "_blank"}, 32'(bus.blank_mask), 32'(blank));
    check({tag, "_err"},   32'(bus.err_mask),   32'(err));
  endtask

  initial begin
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv",   32'(bus.frame_valid), 32'd0);
    check("rst_sync", 32'(bus.sync_lost),   32'd0);
    check_frame("rst", 16'h0000, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Full scan 5,1,2,0
    fv_base = fv_count;
    hold(4'b0001, 7'h5B, 6);
    hold(4'b0010, 7'h30, 6);
    hold(4'b0100, 7'h6D, 6);
    hold(4'b1000, 7'h7E, 6);
    check("scan1_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("scan1", 16'h0215, 4'b0000, 4'b0000);

    // Short dwell on digit 2 is ignored; a later dwell publishes at edge 5
    fv_base = fv_count;
    hold(4'b0001, 7'h7F, 6);
    hold(4'b0010, 7'h79, 6);
    hold(4'b0100, 7'h33, 3);
    hold(4'b1000, 7'h5F, 6);
    check("short_nofv", 32'(fv_count - fv_base), 32'd0);
    bus.dig_sel = 4'b0100;
    bus.seg_in  = '0;
    bus.seg_in[6:0] = 7'h70;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid === 1'b1 && lat == 0) lat = i;
    end
    check("latency", 32'(lat), 32'd5);
    check("short_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("short", 16'h6738, 4'b0000, 4'b0000);

    // Blank and undecodable digits
    fv_base = fv_count;
    hold(4'b0001, 7'h30, 6);
    hold(4'b0010, 7'h00, 6);
    hold(4'b0100, 7'h6D, 6);
    hold(4'b1000, 7'h7C, 6);
    check("flags_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("flags", 16'hF2F1, 4'b0010, 4'b1000);

    // Multi-hot and empty strobes must not disturb a partial frame
    fv_base = fv_count;
    hold(4'b0001, 7'h7B, 6);
    hold(4'b0010, 7'h33, 6);
    hold(4'b0100, 7'h5B, 6);
    hold(4'b0110, 7'h7E, 10);
    hold(4'b0000, 7'h7E, 10);
    check("multihot_nofv", 32'(fv_count - fv_base), 32'd0);
    hold(4'b1000, 7'h7F, 6);
    check("multihot_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("multihot", 16'h8549, 4'b0000, 4'b0000);

    // Repeated digit restarts the scan
    fv_base = fv_count;
    hold(4'b0001, 7'h30, 6);
    hold(4'b0010, 7'h6D, 6);
    hold(4'b0001, 7'h79, 6);
    check("restart_nofv", 32'(fv_count - fv_base), 32'd0);
    hold(4'b0010, 7'h33, 6);
    hold(4'b0100, 7'h5B, 6);
    hold(4'b1000, 7'h5F, 6);
    check("restart_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("restart", 16'h6543, 4'b0000, 4'b0000);

    // Timeout: partial frame dropped, last frame kept
    fv_base = fv_count;
    hold(4'b0001, 7'h30, 6);
    hold(4'b0010, 7'h30, 6);
    hold(4'b0100, 7'h30, 6);
    hold(4'b0000, 7'h00, 1000);
    check("pre_timeout", 32'(bus.sync_lost), 32'd0);
    hold(4'b0000, 7'h00, 30);
    check("timeout", 32'(bus.sync_lost), 32'd1);
    check("timeout_bcd", 32'(bus.bcd_out), 32'h6543);
    hold(4'b1000, 7'h79, 6);
    check("resync", 32'(bus.sync_lost), 32'd0);
    check("timeout_nofv", 32'(fv_count - fv_base), 32'd0);
    hold(4'b0001, 7'h6D, 6);
    hold(4'b0010, 7'h6D, 6);
    hold(4'b0100, 7'h6D, 6);
    check("resync_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("resync", 16'h3222, 4'b0000, 4'b0000);

    // Reset mid-frame discards partial captures
    hold(4'b0001, 7'h7F, 6);
    hold(4'b0010, 7'h7F, 6);
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("midrst_fv",   32'(bus.frame_valid), 32'd0);
    check("midrst_sync", 32'(bus.sync_lost),   32'd0);
    check_frame("midrst", 16'h0000, 4'b0000, 4'b0000);
    fv_base = fv_count;
    hold(4'b0100, 7'h7B, 6);
    hold(4'b1000, 7'h5F, 6);
    check("midrst_nofv", 32'(fv_count - fv_base), 32'd0);
    hold(4'b0001, 7'h33, 6);
    hold(4'b0010, 7'h30, 6);
    check("postrst_fv", 32'(fv_count - fv_base), 32'd1);
    check_frame("postrst", 16'h6914, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
